text_pixel_gen: RTL

TEXT_PIXEL_GEN -- requirements
Module: text_pixel_gen

---
 rtl/text_pixel_gen.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/text_pixel_gen.sv
// Character-cell text renderer: 80x30 cells of 8x16 pixels with a blinking cursor.
// Three-stage pipeline: text-buffer read, font read, registered colour/sync output.
module text_pixel_gen #(
  parameter logic [11:0] FG_COLOR     = 12'hFFF,
  parameter logic [11:0] BG_COLOR     = 12'h000,
  parameter int          BLINK_FRAMES = 30
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  pixel_x,
  input  logic [9:0]  pixel_y,
  input  logic        video_on,
  input  logic        hsync_in,
  input  logic        vsync_in,
  output logic [11:0] char_addr,
  input  logic [7:0]  char_code,
  output logic [10:0] font_addr,
  input  logic [7:0]  font_data,
  input  logic [6:0]  cursor_x,
  input  logic [4:0]  cursor_y,
  input  logic        cursor_en,
  output logic [11:0] rgb,
  output logic        hsync_out,
  output logic        vsync_out
);

  localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);

  logic [6:0]  col_s;
  logic [4:0]  row_s;
  logic        cursor_ok_s;
  logic        cursor_hit_s;

  logic [3:0]  s1_y_r;
  logic [2:0]  s1_x_r;
  logic        s1_video_r;
  logic        s1_hsync_r;
  logic        s1_vsync_r;
  logic        s1_hit_r;

  logic [2:0]  s2_x_r;
  logic        s2_video_r;
  logic        s2_hsync_r;
  logic        s2_vsync_r;
  logic        s2_hit_r;
  logic        s2_rev_r;

  logic        prev_vsync_r;
  logic        frame_edge_s;
  logic [7:0]  blink_cnt_r;
  logic        blink_on_r;

  logic        pixel_bit_s;
  logic        eff_bit_s;
  logic [11:0] rgb_next_s;

  logic [11:0] rgb_r;
  logic        hsync_r;
  logic        vsync_r;

  assign col_s = pixel_x[9:3];
  assign row_s = pixel_y[8:4];

  // row*80 + col built from shifts so no multiplier is needed
  assign char_addr = {1'b0, row_s, 6'b000000}
                   + {3'b000, row_s, 4'b0000}
                   + {5'b00000, col_s};

  // An off-grid cursor position must never match, even for blanking-region columns
  assign cursor_ok_s  = (cursor_x < 7'd80) && (cursor_y < 5'd30);
  assign cursor_hit_s = cursor_ok_s && (col_s == cursor_x) && (row_s == cursor_y);

  assign font_addr = {char_code[6:0], s1_y_r};

  // Stage 1: sideband aligned with the text-buffer read
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_y_r     <= 4'd0;
      s1_x_r     <= 3'd0;
      s1_video_r <= 1'b0;
      s1_hsync_r <= 1'b1;
      s1_vsync_r <= 1'b1;
      s1_hit_r   <= 1'b0;
    end else begin
      s1_y_r     <= pixel_y[3:0];
      s1_x_r     <= pixel_x[2:0];
      s1_video_r <= video_on;
      s1_hsync_r <= hsync_in;
      s1_vsync_r <= vsync_in;
      s1_hit_r   <= cursor_hit_s;
    end
  end

  // Stage 2: sideband aligned with the font read, plus the reverse-video bit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_x_r     <= 3'd0;
      s2_video_r <= 1'b0;
      s2_hsync_r <= 1'b1;
      s2_vsync_r <= 1'b1;
      s2_hit_r   <= 1'b0;
      s2_rev_r   <= 1'b0;
    end else begin
      s2_x_r     <= s1_x_r;
      s2_video_r <= s1_video_r;
      s2_hsync_r <= s1_hsync_r;
      s2_vsync_r <= s1_vsync_r;
      s2_hit_r   <= s1_hit_r;
      s2_rev_r   <= char_code[7];
    end
  end

  assign frame_edge_s = prev_vsync_r & ~vsync_in;

  // Blink phase keeps running regardless of cursor_en
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_vsync_r <= 1'b1;
      blink_cnt_r  <= 8'd0;
      blink_on_r   <= 1'b1;
    end else begin
      prev_vsync_r <= vsync_in;
      if (frame_edge_s) begin
        if (blink_cnt_r == BLINK_LAST) begin
          blink_cnt_r <= 8'd0;
          blink_on_r  <= ~blink_on_r;
        end else begin
          blink_cnt_r <= blink_cnt_r + 8'd1;
        end
      end else begin
        blink_cnt_r <= blink_cnt_r;
        blink_on_r  <= blink_on_r;
      end
    end
  end

  // Pixel selection and colour mapping for the output register
  always_comb begin
    pixel_bit_s = font_data[3'd7 - s2_x_r];
    eff_bit_s   = pixel_bit_s ^ s2_rev_r ^ (s2_hit_r & cursor_en & blink_on_r);
    rgb_next_s  = 12'h000;
    if (s2_video_r) begin
      if (eff_bit_s) begin
        rgb_next_s = FG_COLOR;
      end else begin
        rgb_next_s = BG_COLOR;
      end
    end else begin
      rgb_next_s = 12'h000;
    end
  end

  // Stage 3: registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rgb_r   <= 12'h000;
      hsync_r <= 1'b1;
      vsync_r <= 1'b1;
    end else begin
      rgb_r   <= rgb_next_s;
      hsync_r <= s2_hsync_r;
      vsync_r <= s2_vsync_r;
    end
  end

  assign rgb       = rgb_r;
  assign hsync_out = hsync_r;
  assign vsync_out = vsync_r;

endmodule
